pmem_burst_ctrl: RTL

- Physical-memory-side controller; consumes the 4-beat x 64-bit burst interface driven by the cache hierarchy's cacheline adaptor (pmem_read/pmem_write/pmem_address/pmem_wdata) and returns pmem_rdata/pmem_resp.
- Converts each 256-bit line burst into four single-beat accesses on a synchronous 64-bit SRAM port with 1-cycle read latency.
- Adds a programmable access latency to model DRAM first-beat delay.

---
 rtl/pmem_burst_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/pmem_burst_ctrl.sv
// Physical-memory burst controller: turns a 4-beat x 64-bit line burst into four single-beat SRAM accesses.
// Latency: first pmem_resp LATENCY+1 cycles after the request is sampled in IDLE; bursts are 4 back-to-back beats.
// Backpressure: none on the SRAM side; the requester holds pmem_read/pmem_write until the last beat. One DONE gap follows each burst.
// Optional build macro PMEM_BURST_STATS_EN adds rd_bursts/wr_bursts/busy_cycles counters.
module pmem_burst_ctrl #(
  parameter int LATENCY = 4,   // wait cycles before the first beat, 1..255
  parameter int ADDR_W  = 32,  // width of pmem_address
  parameter int RAM_AW  = 24   // SRAM word-address width (64-bit words)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [ADDR_W-1:0] pmem_address,
  input  logic [63:0]       pmem_wdata,
  output logic [63:0]       pmem_rdata,
  output logic              pmem_resp,
  output logic              ram_re,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [63:0]       ram_wdata,
  input  logic [63:0]       ram_rdata
`ifdef PMEM_BURST_STATS_EN
  ,
  output logic [31:0]       rd_bursts,
  output logic [31:0]       wr_bursts,
  output logic [31:0]       busy_cycles
`endif
);

  // Controller states
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_RBURST = 3'd2;
  localparam logic [2:0] S_WBURST = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // A line is 32 bytes, so the line address drops the low 5 byte-address bits;
  // a word address is the line address with the 2-bit beat index appended.
  localparam int LINE_W = ADDR_W - 5;
  localparam int WORD_W = LINE_W + 2;

  // The wait counter is loaded with LATENCY-1 so that WAIT lasts LATENCY cycles.
  localparam logic [7:0] WCNT_INIT = 8'(LATENCY - 1);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [LINE_W-1:0] line_addr;
  logic              op_read;
  logic [7:0]        wcnt;
  logic [1:0]        beat;
  logic              req;
  logic              wait_done;
  logic              last_beat;
  logic [WORD_W-1:0] cur_word;
  logic [WORD_W-1:0] next_word;

  // Byte-offset bits within a line carry no meaning for this controller.
  logic              unused_addr_bits;
  assign unused_addr_bits = ^pmem_address[4:0];

  assign req       = pmem_read | pmem_write;
  assign wait_done = (wcnt == 8'd0);
  assign last_beat = (beat == 2'd3);

  // Word addresses for the beat being transferred and for the SRAM read
  // issued one cycle ahead (the SRAM returns data the cycle after ram_re).
  assign cur_word  = {line_addr, beat};
  assign next_word = {line_addr, 2'(beat + 2'd1)};

  // Next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_done) begin
          state_nxt = op_read ? S_RBURST : S_WBURST;
        end
      end
      S_RBURST, S_WBURST: begin
        if (last_beat) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // Requests are deliberately ignored here so the adaptor can drop its
        // request after the last beat without starting a phantom burst.
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; reset aborts any burst in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch line address and operation at acceptance; read wins over write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_addr <= '0;
      op_read   <= 1'b0;
    end else if (state == S_IDLE && req) begin
      line_addr <= pmem_address[ADDR_W-1:5];
      op_read   <= pmem_read;
    end
  end

  // First-beat delay counter: loaded on acceptance, counts down in WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= 8'd0;
    end else if (state == S_IDLE && req) begin
      wcnt <= WCNT_INIT;
    end else if (state == S_WAIT && !wait_done) begin
      wcnt <= wcnt - 8'd1;
    end
  end

  // Beat counter: advances every burst cycle, so it wraps 3->0 exactly on burst exit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat <= 2'd0;
    end else if (state == S_RBURST || state == S_WBURST) begin
      beat <= beat + 2'd1;
    end
  end

  // Output decode; everything is forced to zero outside the states that use it,
  // which also makes the outputs drop in the same cycle as an async reset.
  always_comb begin
    pmem_resp  = 1'b0;
    pmem_rdata = 64'd0;
    ram_re     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = 64'd0;
    case (state)
      S_WAIT: begin
        // Prefetch beat 0 in the last wait cycle so data lines up with the first resp.
        if (wait_done && op_read) begin
          ram_re   = 1'b1;
          ram_addr = RAM_AW'(cur_word);
        end
      end
      S_RBURST: begin
        pmem_resp  = 1'b1;
        pmem_rdata = ram_rdata;
        if (!last_beat) begin
          ram_re   = 1'b1;
          ram_addr = RAM_AW'(next_word);
        end
      end
      S_WBURST: begin
        pmem_resp = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = RAM_AW'(cur_word);
        ram_wdata = pmem_wdata;
      end
      default: begin
      end
    endcase
  end

`ifdef PMEM_BURST_STATS_EN
  // Burst and occupancy counters; free-running, wrap at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bursts   <= 32'd0;
      wr_bursts   <= 32'd0;
      busy_cycles <= 32'd0;
    end else begin
      if (state == S_RBURST && last_beat) begin
        rd_bursts <= rd_bursts + 32'd1;
      end
      if (state == S_WBURST && last_beat) begin
        wr_bursts <= wr_bursts + 32'd1;
      end
      if (state != S_IDLE) begin
        busy_cycles <= busy_cycles + 32'd1;
      end
    end
  end
`endif

endmodule
